// File: rtl/vx_gbar_hub_pkg.sv
// Shared definitions for the global barrier hub: width helpers, the
// default-configuration arrival record and the tracker outcome encoding.
package vx_gbar_hub_pkg;

    // Index width that never collapses to zero bits.
    function automatic int gbar_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Widths for the default cluster (8 barriers, 16 cores).
    localparam int GBAR_BAR_W  = gbar_width(8);
    localparam int GBAR_CORE_W = $clog2(16);

    // One barrier arrival as seen on a socket gbar bus (default widths).
    typedef struct packed {
        logic [GBAR_BAR_W-1:0]  id;
        logic [GBAR_CORE_W-1:0] size_m1;
        logic [GBAR_CORE_W-1:0] core_id;
    } gbar_req_t;

    // What the tracker reports for the arrival it just processed.
    typedef enum logic [1:0] {
        GBAR_NONE = 2'd0,
        GBAR_REL  = 2'd1,
        GBAR_ERR  = 2'd2
    } gbar_evt_e;

endpackage

// File: rtl/vx_gbar_hub_slot.sv
// One barrier slot: arrival count, latched participant count and the
// per-core arrival mask. Flags duplicate / size-mismatched arrivals and
// the releasing arrival combinationally; state moves on the clock edge.
module vx_gbar_hub_slot #(
    parameter  int NUM_CORES = 16,
    localparam int CORE_W    = $clog2(NUM_CORES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arr_i,
    input  logic [CORE_W-1:0] size_m1_i,
    input  logic [CORE_W-1:0] core_i,
    output logic              rel_o,
    output logic              err_o,
    output logic              busy_o
);

    logic [CORE_W-1:0]    cnt_q, cnt_d;
    logic [CORE_W-1:0]    size_q, size_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic                 idle, dup, mism;

    assign idle   = (cnt_q == '0) && (mask_q == '0);
    assign dup    = mask_q[core_i];
    assign mism   = !idle && (size_m1_i != size_q);
    assign err_o  = arr_i && (dup || mism);
    // On an idle slot cnt is 0, so a size_m1 of 0 releases immediately.
    assign rel_o  = arr_i && !dup && !mism && (cnt_q == size_m1_i);
    assign busy_o = !idle;

    // Next slot state: clear on release, count and mark on a good arrival.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        size_d = size_q;
        mask_d = mask_q;
        if (rel_o) begin
            cnt_d  = '0;
            size_d = '0;
            mask_d = '0;
        end else if (arr_i && !err_o) begin
            cnt_d          = cnt_q + 1'b1;
            mask_d[core_i] = 1'b1;
            if (idle) size_d = size_m1_i;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the mask is reset along with cnt because idle detection reads it; a stale bit would fake a duplicate.
        if (!reset) begin
            cnt_q  <= '0;
            size_q <= '0;
            mask_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt_q  <= cnt_d;
            size_q <= size_d;
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/vx_gbar_hub.sv
// Cluster global barrier hub: round-robin arbiter over the socket gbar
// buses, optional register stage, one tracking slot per barrier, and
// registered release / error pulses.
// Optional build macro GBAR_HUB_PERF_EN adds perf_releases / perf_stalls.
module vx_gbar_hub
    import vx_gbar_hub_pkg::*;
#(
    parameter  int NUM_REQS     = 4,
    parameter  int NUM_CORES    = 16,
    parameter  int NUM_BARRIERS = 8,
    parameter  int IN_REG       = 0,
    localparam int BAR_W        = gbar_width(NUM_BARRIERS),
    localparam int CORE_W       = $clog2(NUM_CORES),
    localparam int PTR_W        = gbar_width(NUM_REQS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    input  logic [NUM_REQS-1:0][BAR_W-1:0]   req_id,
    input  logic [NUM_REQS-1:0][CORE_W-1:0]  req_size_m1,
    input  logic [NUM_REQS-1:0][CORE_W-1:0]  req_core_id,
    output logic [NUM_REQS-1:0]              req_ready,
    output logic                             rsp_valid,
    output logic [BAR_W-1:0]                 rsp_id,
    output logic                             err_valid,
    output logic [BAR_W-1:0]                 err_id,
    output logic                             busy
`ifdef GBAR_HUB_PERF_EN
    ,
    output logic [31:0]                      perf_releases,
    output logic [31:0]                      perf_stalls
`endif
);

    typedef struct packed {
        logic [BAR_W-1:0]  id;
        logic [CORE_W-1:0] size_m1;
        logic [CORE_W-1:0] core_id;
    } req_t;

    logic [PTR_W-1:0]        ptr_q, ptr_d, gnt_idx, scan_idx;
    logic                    gnt_vld, hs, trk_vld, stage_busy, id_ok;
    req_t                    arb_req, trk_req;
    logic [NUM_BARRIERS-1:0] sel_vec, rel_vec, err_vec, busy_vec;
    gbar_evt_e               evt_d;
    logic                    rsp_valid_q, err_valid_q;
    logic [BAR_W-1:0]        rsp_id_q, err_id_q;

    // Round-robin search for the first requester at or after the pointer.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            scan_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQS);
            if (!gnt_vld && req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // The tracker never stalls, so every grant is a handshake (none in reset).
    assign hs = gnt_vld && reset;

    // One-hot ready for the granted socket; pointer moves past the winner.
    always_comb begin
        req_ready = '0;
        ptr_d     = ptr_q;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == PTR_W'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Arbiter priority pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign arb_req.id      = req_id[gnt_idx];
    assign arb_req.size_m1 = req_size_m1[gnt_idx];
    assign arb_req.core_id = req_core_id[gnt_idx];

    if (IN_REG != 0) begin : g_in_reg
        logic vld_q;
        req_t req_q;
        // Register stage between arbiter and tracker.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_q <= 1'b0;
                req_q <= '0;
            end else begin
                vld_q <= hs;
                req_q <= arb_req;
            end
        end
        assign trk_vld    = vld_q;
        assign trk_req    = req_q;
        assign stage_busy = vld_q;
    end else begin : g_no_reg
        assign trk_vld    = hs;
        assign trk_req    = arb_req;
        assign stage_busy = 1'b0;
    end

    assign id_ok = {1'b0, trk_req.id} < (BAR_W + 1)'(NUM_BARRIERS);

    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
        assign sel_vec[b] = trk_vld && id_ok && (trk_req.id == BAR_W'(b));
        vx_gbar_hub_slot #(.NUM_CORES(NUM_CORES)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .arr_i     (sel_vec[b]),
            .size_m1_i (trk_req.size_m1),
            .core_i    (trk_req.core_id),
            .rel_o     (rel_vec[b]),
            .err_o     (err_vec[b]),
            .busy_o    (busy_vec[b])
        );
    end

    // Outcome of the arrival in the tracker this cycle (at most one).
    always_comb begin
        evt_d = GBAR_NONE;
        if (trk_vld && !id_ok) evt_d = GBAR_ERR;
        else if (|rel_vec)     evt_d = GBAR_REL;
        else if (|err_vec)     evt_d = GBAR_ERR;
    end

    // Registered single-cycle release / error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            err_valid_q <= 1'b0;
            err_id_q    <= '0;
        end else begin
            rsp_valid_q <= (evt_d == GBAR_REL);
            rsp_id_q    <= (evt_d == GBAR_REL) ? trk_req.id : '0;
            err_valid_q <= (evt_d == GBAR_ERR);
            err_id_q    <= (evt_d == GBAR_ERR) ? trk_req.id : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign err_valid = err_valid_q;
    assign err_id    = err_id_q;
    assign busy      = (|busy_vec) || stage_busy;

`ifdef GBAR_HUB_PERF_EN
    logic [31:0] rel_cnt_q, stall_cnt_q;

    // Release and stall counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (rsp_valid_q)                 rel_cnt_q   <= rel_cnt_q + 32'd1;
            if (|(req_valid & ~req_ready))   stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_releases = rel_cnt_q;
    assign perf_stalls   = stall_cnt_q;
`else
    // Performance counters not built.
`endif

endmodule
